// File: rtl/stopwatch_pkg.sv
// Types and glyph constants shared by stop_watch and its seven-segment display driver.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    CLEAR   = 3'b010,
    RUNNING = 3'b100
  } mode_t;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_SHIFT,
    CV_LOAD
  } conv_state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_I     = 7'h06;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_E     = 7'h79;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 5-bit binary to tens (0-3) and ones (0-9),
// one shift per clock, result registers written in the load state.
module bin2bcd_seq
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] bin_i,
  output logic       busy_o,
  output logic [1:0] tens_o,
  output logic [3:0] ones_o
);

  conv_state_t state;
  logic [12:0] sr;   // {tens nibble, ones nibble, binary}
  logic [12:0] adj;
  logic [2:0]  iter;

  always_comb begin
    adj = sr;
    if (sr[8:5] >= 4'd5)  adj[8:5]  = sr[8:5] + 4'd3;
    if (sr[12:9] >= 4'd5) adj[12:9] = sr[12:9] + 4'd3;
  end

  assign busy_o = (state != CV_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CV_IDLE;
      sr     <= '0;
      iter   <= '0;
      tens_o <= '0;
      ones_o <= '0;
    end else begin
      case (state)
        CV_IDLE: begin
          if (start) begin
            sr    <= {8'h00, bin_i};
            iter  <= '0;
            state <= CV_SHIFT;
          end
        end
        CV_SHIFT: begin
          sr   <= adj << 1;
          iter <= iter + 3'd1;
          if (iter == 3'd4) state <= CV_LOAD;
        end
        CV_LOAD: begin
          tens_o <= sr[10:9];
          ones_o <= sr[8:5];
          state  <= CV_IDLE;
        end
        default: state <= CV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// Three-digit multiplexed seven-segment driver for stop_watch: ones, tens
// (leading zero blanked) and a mode letter, scanned REFRESH_DIV cycles per digit.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic [4:0] time_i,
  input  logic [2:0] mode_i,
  output logic [6:0] seg_o,
  output logic [2:0] an_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [4:0]    last_time;
  logic          start;
  logic [1:0]    tens;
  logic [3:0]    ones;
  mode_t         mode_q;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [6:0]    mode_glyph;

  // Changes that arrive while busy are picked up once the converter is idle again.
  assign start = (time_i != last_time) && !busy_o;

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst    (rst_i),
    .start  (start),
    .bin_i  (time_i),
    .busy_o (busy_o),
    .tens_o (tens),
    .ones_o (ones)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      last_time <= '0;
      mode_q    <= IDLE;
    end else begin
      if (start) last_time <= time_i;
      mode_q <= mode_t'(mode_i);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    mode_glyph = SEG_E;
    case (mode_q)
      IDLE:    mode_glyph = SEG_I;
      CLEAR:   mode_glyph = SEG_C;
      RUNNING: mode_glyph = SEG_R;
      default: mode_glyph = SEG_E;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      seg_o <= 7'h3F;
      an_o  <= 3'b001;
    end else begin
      case (digit_idx)
        2'd1: begin
          an_o  <= 3'b010;
          seg_o <= (tens == 2'd0) ? SEG_BLANK : digit_glyph({2'b00, tens});
        end
        2'd2: begin
          an_o  <= 3'b100;
          seg_o <= mode_glyph;
        end
        default: begin
          an_o  <= 3'b001;
          seg_o <= digit_glyph(ones);
        end
      endcase
    end
  end

endmodule
